// File: rtl/sdram_word_port.sv
// rtl/sdram_word_port.sv - 16-bit word FIFO responder: block unpacker feeding reads, block packer draining writes
// Optional status flag registers are built when SDRAM_WORD_PORT_STATUS_EN is defined.
module sdram_word_port #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [127:0]      blk_in,
  input  logic              blk_in_valid,
  output logic              blk_in_ready,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  output logic [15:0]       ReadUse,
  output logic              SDRAM_read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [15:0]       WriteUse,
  output logic              SDRAM_write,
  output logic [127:0]      blk_out,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  output logic [3:0]        status
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] ROOM_LVL = PW'(DEPTH - 8);

  typedef enum logic {U_IDLE, U_PUSH} u_state_t;
  typedef enum logic {P_COLLECT, P_HOLD} p_state_t;

  u_state_t          u_state_q, u_state_d;
  p_state_t          p_state_q, p_state_d;
  logic [127:0]      u_sr_q, u_sr_d;
  logic [2:0]        u_cnt_q, u_cnt_d;
  logic [2:0]        p_cnt_q, p_cnt_d;
  logic [127:0]      p_blk_q, p_blk_d;
  logic [PW-1:0]     rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
  logic [PW-1:0]     wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic [DATA_W-1:0] rd_mem [DEPTH];
  logic [DATA_W-1:0] wr_mem [DEPTH];

  logic [PW-1:0]     rd_use, wr_use;
  logic              rd_empty, wr_empty, wr_full;
  logic              rd_push, rd_pop, wr_push, wr_pop;
  logic [DATA_W-1:0] rd_head, wr_head;

  assign rd_use   = rd_wp_q - rd_rp_q;
  assign wr_use   = wr_wp_q - wr_rp_q;
  assign rd_empty = (rd_use == '0);
  assign wr_empty = (wr_use == '0);
  assign wr_full  = (wr_use == FULL_LVL);
  assign rd_head  = rd_mem[rd_rp_q[DEPTH_LOG2-1:0]];
  assign wr_head  = wr_mem[wr_rp_q[DEPTH_LOG2-1:0]];

  // Pops look only at registered pointers, so a word pushed this cycle is never popped this cycle.
  assign rd_pop  = read && !rd_empty;
  assign wr_push = write && !wr_full;

  always_comb begin
    u_state_d    = u_state_q;
    u_sr_d       = u_sr_q;
    u_cnt_d      = u_cnt_q;
    blk_in_ready = 1'b0;
    rd_push      = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        blk_in_ready = !iRST && (rd_use <= ROOM_LVL);
        if (blk_in_valid && blk_in_ready) begin
          u_sr_d    = blk_in;
          u_cnt_d   = '0;
          u_state_d = U_PUSH;
        end
      end
      U_PUSH: begin
        rd_push = 1'b1;
        u_sr_d  = {{DATA_W{1'b0}}, u_sr_q[127:DATA_W]};
        u_cnt_d = u_cnt_q + 3'd1;
        if (u_cnt_q == 3'd7) u_state_d = U_IDLE;
      end
      default: u_state_d = U_IDLE;
    endcase
  end

  always_comb begin
    p_state_d = p_state_q;
    p_cnt_d   = p_cnt_q;
    p_blk_d   = p_blk_q;
    wr_pop    = 1'b0;
    case (p_state_q)
      P_COLLECT: begin
        if (!wr_empty) begin
          wr_pop = 1'b1;
          p_blk_d[{p_cnt_q, 4'b0000} +: DATA_W] = wr_head;
          p_cnt_d = p_cnt_q + 3'd1;
          if (p_cnt_q == 3'd7) p_state_d = P_HOLD;
        end
      end
      P_HOLD: begin
        if (blk_out_ready) p_state_d = P_COLLECT;
      end
      default: p_state_d = P_COLLECT;
    endcase
  end

  always_comb begin
    rd_wp_d    = rd_wp_q + PW'(rd_push);
    rd_rp_d    = rd_rp_q + PW'(rd_pop);
    wr_wp_d    = wr_wp_q + PW'(wr_push);
    wr_rp_d    = wr_rp_q + PW'(wr_pop);
    readdata_d = rd_pop ? rd_head : readdata_q;
  end

  always_ff @(posedge iCLK) begin
    if (rd_push) rd_mem[rd_wp_q[DEPTH_LOG2-1:0]] <= u_sr_q[DATA_W-1:0];
    if (wr_push) wr_mem[wr_wp_q[DEPTH_LOG2-1:0]] <= writedata;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      u_state_q  <= U_IDLE;
      p_state_q  <= P_COLLECT;
      u_sr_q     <= '0;
      u_cnt_q    <= '0;
      p_cnt_q    <= '0;
      p_blk_q    <= '0;
      rd_wp_q    <= '0;
      rd_rp_q    <= '0;
      wr_wp_q    <= '0;
      wr_rp_q    <= '0;
      readdata_q <= '0;
    end else begin
      u_state_q  <= u_state_d;
      p_state_q  <= p_state_d;
      u_sr_q     <= u_sr_d;
      u_cnt_q    <= u_cnt_d;
      p_cnt_q    <= p_cnt_d;
      p_blk_q    <= p_blk_d;
      rd_wp_q    <= rd_wp_d;
      rd_rp_q    <= rd_rp_d;
      wr_wp_q    <= wr_wp_d;
      wr_rp_q    <= wr_rp_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata      = readdata_q;
  assign ReadUse       = 16'(rd_use);
  assign WriteUse      = 16'(wr_use);
  assign SDRAM_read    = (u_state_q == U_PUSH);
  assign SDRAM_write   = (wr_use > ROOM_LVL);
  assign blk_out       = p_blk_q;
  assign blk_out_valid = (p_state_q == P_HOLD);

`ifdef SDRAM_WORD_PORT_STATUS_EN
  // {sticky overflow, sticky underflow, drop pulse, empty-read pulse}
  logic [3:0] status_q, status_d;
  logic       wr_drop, rd_underflow;
  assign wr_drop      = write && wr_full;
  assign rd_underflow = read && rd_empty;
  always_comb begin
    status_d = {status_q[3] | wr_drop, status_q[2] | rd_underflow, wr_drop, rd_underflow};
  end
  always_ff @(posedge iCLK) begin
    if (iRST) status_q <= '0;
    else      status_q <= status_d;
  end
  assign status = status_q;
`else
  assign status = 4'b0000;
`endif

endmodule

// File: tb/tb_sdram_word_port.sv
// tb/tb_sdram_word_port.sv - self-checking bench for sdram_word_port
// Status expectations follow SDRAM_WORD_PORT_STATUS_EN.
module tb_sdram_word_port;
  logic         iCLK = 1'b0;
  logic         iRST;
  logic [127:0] blk_in;
  logic         blk_in_valid;
  logic         blk_in_ready;
  logic         read;
  logic [15:0]  readdata;
  logic [15:0]  ReadUse;
  logic         SDRAM_read;
  logic         write;
  logic [15:0]  writedata;
  logic [15:0]  WriteUse;
  logic         SDRAM_write;
  logic [127:0] blk_out;
  logic         blk_out_valid;
  logic         blk_out_ready;
  logic [3:0]   status;

`ifdef SDRAM_WORD_PORT_STATUS_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  sdram_word_port dut (
    .iCLK(iCLK), .iRST(iRST),
    .blk_in(blk_in), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
    .read(read), .readdata(readdata), .ReadUse(ReadUse), .SDRAM_read(SDRAM_read),
    .write(write), .writedata(writedata), .WriteUse(WriteUse), .SDRAM_write(SDRAM_write),
    .blk_out(blk_out), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
    .status(status)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] wd;
    logic [15:0] exp_rdata;
    logic [15:0] exp_ruse;
    logic [15:0] exp_wuse;
    logic        exp_bov;
  } vec_t;

  vec_t vecs [11];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkblk(input logic [15:0] base);
    logic [127:0] b;
    for (int k = 0; k < 8; k++) b[16*k +: 16] = base + 16'(k);
    return b;
  endfunction

  task automatic send_block(input logic [127:0] b);
    int t = 0;
    while (!blk_in_ready && t < 50) begin
      tick();
      t++;
    end
    chk("blk_in_ready_wait", blk_in_ready, 1);
    blk_in = b;
    blk_in_valid = 1'b1;
    tick();
    blk_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (SDRAM_read && t < 20) begin
      tick();
      t++;
    end
    chk("unpack_done", SDRAM_read, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_blk_in_ready"}, blk_in_ready, 0);
    chk({tag, "_readdata"}, readdata, 0);
    chk({tag, "_ReadUse"}, ReadUse, 0);
    chk({tag, "_SDRAM_read"}, SDRAM_read, 0);
    chk({tag, "_WriteUse"}, WriteUse, 0);
    chk({tag, "_SDRAM_write"}, SDRAM_write, 0);
    chk({tag, "_blk_out"}, blk_out, 0);
    chk({tag, "_blk_out_valid"}, blk_out_valid, 0);
    chk({tag, "_status"}, status, 0);
  endtask

  initial begin
    int hi;
    int good;
    int exp_wuse;
    //           rd    wr    wd      rdata     ruse   wuse   bov
    vecs[0]  = '{1'b1, 1'b0, 16'h0,  16'h1110, 16'd7, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'hA0, 16'h1111, 16'd6, 16'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'hA1, 16'h1112, 16'd5, 16'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'hA2, 16'h1112, 16'd5, 16'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'hA3, 16'h1113, 16'd4, 16'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h0,  16'h1113, 16'd4, 16'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'hA4, 16'h1114, 16'd3, 16'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'hA5, 16'h1115, 16'd2, 16'd1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'hA6, 16'h1116, 16'd1, 16'd1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'hA7, 16'h1117, 16'd0, 16'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0,  16'h1117, 16'd0, 16'd0, 1'b1};

    iRST = 1'b1; blk_in = '0; blk_in_valid = 1'b0; read = 1'b0;
    write = 1'b0; writedata = '0; blk_out_ready = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    iRST = 1'b0;
    #1;
    chk("ready_after_release", blk_in_ready, 1);

    // Unpack then drain
    blk_in = mkblk(16'h0000);
    blk_in_valid = 1'b1;
    tick();
    blk_in_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (SDRAM_read) hi++;
      tick();
      if (i < 8) chk($sformatf("unpack_ReadUse_%0d", i), ReadUse, 16'(i + 1));
    end
    chk("sdram_read_cycles", hi, 8);
    for (int k = 0; k < 8; k++) begin
      read = 1'b1;
      tick();
      chk($sformatf("drain_readdata_%0d", k), readdata, 16'(k));
      chk($sformatf("drain_ReadUse_%0d", k), ReadUse, 16'(7 - k));
    end
    read = 1'b0;

    // Table: concurrent pops, pushes and packing
    send_block(mkblk(16'h1110));
    wait_idle();
    chk("table_start_ReadUse", ReadUse, 8);
    for (int i = 0; i < 11; i++) begin
      read = vecs[i].rd;
      write = vecs[i].wr;
      writedata = vecs[i].wd;
      tick();
      chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_ReadUse", i), ReadUse, vecs[i].exp_ruse);
      chk($sformatf("vec%0d_WriteUse", i), WriteUse, vecs[i].exp_wuse);
      chk($sformatf("vec%0d_blk_out_valid", i), blk_out_valid, vecs[i].exp_bov);
    end
    read = 1'b0; write = 1'b0;
    chk("pack_blk_out", blk_out, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    good = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (blk_out_valid && blk_out == 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0) good++;
    end
    chk("hold_stable_cycles", good, 20);
    blk_out_ready = 1'b1;
    tick();
    blk_out_ready = 1'b0;
    chk("valid_after_handshake", blk_out_valid, 0);

    // Empty read
    chk("status_before_empty", status, 0);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("empty_readdata", readdata, 16'h1117);
    chk("empty_ReadUse", ReadUse, 0);
    chk("empty_status_pulse", status, ST_EN ? 4'b0101 : 4'b0000);
    tick();
    chk("empty_status_after", status, ST_EN ? 4'b0100 : 4'b0000);

    // Full write FIFO with the packer holding
    for (int i = 0; i < 264; i++) begin
      write = 1'b1;
      writedata = 16'(i);
      tick();
      exp_wuse = i + 1 - ((i < 8) ? i : 8);
      chk($sformatf("fill_WriteUse_%0d", i), WriteUse, 16'(exp_wuse));
      chk($sformatf("fill_SDRAM_write_%0d", i), SDRAM_write, exp_wuse > 248);
    end
    writedata = 16'hDEAD;
    tick();
    write = 1'b0;
    chk("drop_WriteUse", WriteUse, 256);
    chk("drop_status_pulse", status, ST_EN ? 4'b1110 : 4'b0000);
    tick();
    chk("drop_status_after", status, ST_EN ? 4'b1100 : 4'b0000);
    chk("full_blk_out", blk_out, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

    // Simultaneous push and pop on the read side
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    for (int b = 0; b < 31; b++) begin
      send_block(mkblk({8'(b), 8'h00}));
      wait_idle();
    end
    chk("fill_ReadUse_248", ReadUse, 248);
    chk("ready_at_248", blk_in_ready, 1);
    send_block(mkblk(16'hF000));
    read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("pushpop_ReadUse_%0d", i), ReadUse, 248);
    end
    read = 1'b0;
    chk("pushpop_readdata", readdata, 16'h0007);
    wait_idle();
    send_block(mkblk(16'hF100));
    wait_idle();
    chk("ReadUse_256", ReadUse, 256);
    chk("ready_at_256", blk_in_ready, 0);
    for (int i = 1; i <= 8; i++) begin
      read = 1'b1;
      tick();
      read = 1'b0;
      chk($sformatf("ready_after_pop_%0d", i), blk_in_ready, i == 8);
    end

    // Reset in the middle of an unpack and a pack
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    blk_in = mkblk(16'hC000);
    blk_in_valid = 1'b1;
    write = 1'b1;
    writedata = 16'h0055;
    tick();
    blk_in_valid = 1'b0;
    tick();
    tick();
    write = 1'b0;
    tick();
    chk("mid_SDRAM_read", SDRAM_read, 1);
    chk("mid_ReadUse", ReadUse, 3);
    iRST = 1'b1; read = 1'b1; write = 1'b1; blk_in_valid = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    iRST = 1'b0; read = 1'b0; write = 1'b0; blk_in_valid = 1'b0;
    send_block(mkblk(16'h5E00));
    wait_idle();
    for (int k = 0; k < 8; k++) begin
      read = 1'b1;
      writedata = 16'h00B0 + 16'(k);
      write = 1'b1;
      tick();
      chk($sformatf("fresh_readdata_%0d", k), readdata, 16'h5E00 + 16'(k));
    end
    read = 1'b0; write = 1'b0;
    tick();
    chk("fresh_blk_out_valid", blk_out_valid, 1);
    chk("fresh_blk_out", blk_out, 128'h00B7_00B6_00B5_00B4_00B3_00B2_00B1_00B0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
